dht11_responder: RTL and testbench

//  DHT11 sensor-side emulator on the single-wire open-drain bus: detects the host start pulse,

---
 rtl/dht11_pkg.sv | 38 +++
 rtl/dht11_phase_timer.sv | 27 ++
 rtl/dht11_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dht11_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM states, default phase timings in microseconds,
// frame geometry and the checksum rule used by both bus ends.
package dht11_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START_DET,
        WAIT_REL,
        WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } dht11_state_e;

    localparam int FRAME_BITS  = 40;
    localparam int FRAME_BYTES = FRAME_BITS / 8;

    localparam int DEF_CLK_PER_US   = 10;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_WAIT_US      = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_ZERO_HIGH_US = 26;
    localparam int DEF_ONE_HIGH_US  = 70;
    localparam int DEF_END_LOW_US   = 50;

    // Checksum is the plain 8-bit sum of the four data bytes, carries discarded.
    function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] b2,
                                                  input logic [7:0] b3);
        return b0 + b1 + b2 + b3;
    endfunction

endpackage

// File: rtl/dht11_phase_timer.sv
// Loadable down-counter shared by every bus phase. Loading V gives V+1 cycles
// until expired, so callers load (phase_cycles - 1).
module dht11_phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: accepts the host start pulse, sends the response
// preamble and a 40-bit MSB-first frame on an open-drain line (drive low only).
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US   = DEF_CLK_PER_US,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int WAIT_US      = DEF_WAIT_US,
    parameter int RESP_LOW_US  = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int ZERO_HIGH_US = DEF_ZERO_HIGH_US,
    parameter int ONE_HIGH_US  = DEF_ONE_HIGH_US,
    parameter int END_LOW_US   = DEF_END_LOW_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dq_in,
    output logic       dq_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    output logic       busy,
    output logic       frame_done
);

    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(START_MIN_US * CLK_PER_US + 1);
    localparam int IW          = $clog2(FRAME_BITS);

    // The IDLE cycle that first sees the low level counts toward the start
    // pulse, so START_DET itself runs one cycle shorter than the others.
    localparam logic [CW-1:0] LD_START     = CW'(START_MIN_US * CLK_PER_US - 2);
    localparam logic [CW-1:0] LD_WAIT      = CW'(WAIT_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LD_RESP_LOW  = CW'(RESP_LOW_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LD_RESP_HIGH = CW'(RESP_HIGH_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LD_BIT_LOW   = CW'(BIT_LOW_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LD_ZERO_HIGH = CW'(ZERO_HIGH_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LD_ONE_HIGH  = CW'(ONE_HIGH_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LD_END_LOW   = CW'(END_LOW_US * CLK_PER_US - 1);
    localparam logic [IW-1:0] LAST_BIT     = IW'(FRAME_BITS - 1);

    dht11_state_e            state_reg, state_next;
    logic [SYNC_STAGES-1:0]  sync_reg;
    logic                    dq_s;
    logic [FRAME_BITS-1:0]   shreg_reg, shreg_next;
    logic [IW-1:0]           bit_idx_reg, bit_idx_next;
    logic                    dq_oe_reg, dq_oe_next;
    logic                    busy_reg, busy_next;
    logic                    frame_done_reg, frame_done_next;
    logic                    tmr_load;
    logic [CW-1:0]           tmr_load_val;
    logic                    tmr_expired;
    logic [7:0]              frame_bytes [FRAME_BYTES];
    logic [FRAME_BITS-1:0]   frame_word;

    // Synchronizer resets to the released (pulled-up) level so reset never
    // looks like a host start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], dq_in};
        end
    end

    assign dq_s = sync_reg[SYNC_STAGES-1];

    assign frame_bytes[0] = hum_int;
    assign frame_bytes[1] = hum_dec;
    assign frame_bytes[2] = tmp_int;
    assign frame_bytes[3] = tmp_dec;
    assign frame_bytes[4] = frame_checksum(hum_int, hum_dec, tmp_int, tmp_dec);

    for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_pack
        assign frame_word[FRAME_BITS-1-8*gi -: 8] = frame_bytes[gi];
    end

    dht11_phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            bit_idx_reg    <= '0;
            dq_oe_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_idx_reg    <= bit_idx_next;
            dq_oe_reg      <= dq_oe_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        bit_idx_next    = bit_idx_reg;
        frame_done_next = 1'b0;
        tmr_load        = 1'b0;
        tmr_load_val    = '0;

        case (state_reg)
            IDLE: begin
                if (!dq_s) begin
                    state_next   = START_DET;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_START;
                end
            end
            START_DET: begin
                if (dq_s) begin
                    state_next = IDLE;
                end else if (tmr_expired) begin
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (dq_s) begin
                    state_next   = WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_WAIT;
                end
            end
            WAIT: begin
                if (tmr_expired) begin
                    state_next   = RESP_LOW;
                    shreg_next   = frame_word;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_RESP_LOW;
                end
            end
            RESP_LOW: begin
                if (tmr_expired) begin
                    state_next   = RESP_HIGH;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_RESP_HIGH;
                end
            end
            RESP_HIGH: begin
                if (tmr_expired) begin
                    state_next   = BIT_LOW;
                    bit_idx_next = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_BIT_LOW;
                end
            end
            BIT_LOW: begin
                if (tmr_expired) begin
                    state_next   = BIT_HIGH;
                    tmr_load     = 1'b1;
                    tmr_load_val = shreg_reg[FRAME_BITS-1] ? LD_ONE_HIGH : LD_ZERO_HIGH;
                end
            end
            BIT_HIGH: begin
                if (tmr_expired) begin
                    shreg_next = {shreg_reg[FRAME_BITS-2:0], 1'b0};
                    tmr_load   = 1'b1;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next   = END_LOW;
                        tmr_load_val = LD_END_LOW;
                    end else begin
                        state_next   = BIT_LOW;
                        bit_idx_next = bit_idx_reg + IW'(1);
                        tmr_load_val = LD_BIT_LOW;
                    end
                end
            end
            END_LOW: begin
                if (tmr_expired) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs follow the next state so they change on the same edge as the state.
        dq_oe_next = (state_next == RESP_LOW) || (state_next == BIT_LOW) ||
                     (state_next == END_LOW);
        busy_next  = (state_next != IDLE) && (state_next != START_DET);
    end

    assign dq_oe      = dq_oe_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: host model on a wired-AND bus, frame
// capture by measuring every low/high phase of dq_oe in clock cycles.
module tb_dht11_responder;
    import dht11_pkg::*;

    // CLK_PER_US lowered to 2 so that several full frames fit in a short run.
    localparam int CPU           = 2;
    localparam int START_MIN     = 1000;
    localparam int START_CYC     = START_MIN * CPU;
    localparam int WAIT_CYC      = 30 * CPU;
    localparam int RESP_LOW_CYC  = 80 * CPU;
    localparam int RESP_HIGH_CYC = 80 * CPU;
    localparam int BIT_LOW_CYC   = 50 * CPU;
    localparam int ZERO_CYC      = 26 * CPU;
    localparam int ONE_CYC       = 70 * CPU;
    localparam int END_CYC       = 50 * CPU;
    localparam int RUN_LIMIT     = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_low;
    logic       dq_in;
    logic       dq_oe;
    logic       busy;
    logic       frame_done;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
    int         checks = 0;
    int         errors = 0;
    int         fd_cnt = 0;

    always #5 clk = ~clk;

    // Open-drain bus with pull-up: low if either end pulls it.
    assign dq_in = ~(host_low | dq_oe);

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    dht11_responder #(
        .CLK_PER_US   (CPU),
        .START_MIN_US (START_MIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dq_in      (dq_in),
        .dq_oe      (dq_oe),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .tmp_int    (tmp_int),
        .tmp_dec    (tmp_dec),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        hum_int = a; hum_dec = b; tmp_int = c; tmp_dec = d;
    endtask

    task automatic host_start(input int low_cyc);
        host_low = 1'b1;
        repeat (low_cyc) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (dq_oe === lvl && n < RUN_LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_oe_high(output int lat);
        lat = 0;
        while (dq_oe !== 1'b1 && lat < WAIT_CYC + 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Called right after host release; measures the whole response and frame.
    task automatic capture_frame(input logic [39:0] exp, input string tag);
        int          lat, n;
        logic [39:0] got;
        got = '0;
        wait_oe_high(lat);
        checks++;
        // 2 synchronizer flops plus the registered state/output stage
        if (lat != WAIT_CYC + 3) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, WAIT_CYC + 3);
            if (dq_oe !== 1'b1) return;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy during response: got %b, expected 1", tag, busy);
        end
        set_data(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        run_len(1'b1, n);
        checks++;
        if (n != RESP_LOW_CYC) begin
            errors++;
            $display("FAIL %s resp_low: got %0d, expected %0d", tag, n, RESP_LOW_CYC);
        end
        if (n >= RUN_LIMIT) return;
        run_len(1'b0, n);
        checks++;
        if (n != RESP_HIGH_CYC) begin
            errors++;
            $display("FAIL %s resp_high: got %0d, expected %0d", tag, n, RESP_HIGH_CYC);
        end
        if (n >= RUN_LIMIT) return;
        for (int b = 39; b >= 0; b--) begin
            run_len(1'b1, n);
            checks++;
            if (n != BIT_LOW_CYC) begin
                errors++;
                $display("FAIL %s bit%0d low: got %0d, expected %0d", tag, b, n, BIT_LOW_CYC);
            end
            if (n >= RUN_LIMIT) return;
            run_len(1'b0, n);
            got[b] = (n > (ZERO_CYC + ONE_CYC) / 2);
            checks++;
            if (n != (exp[b] ? ONE_CYC : ZERO_CYC)) begin
                errors++;
                $display("FAIL %s bit%0d high: got %0d, expected %0d", tag, b, n,
                         exp[b] ? ONE_CYC : ZERO_CYC);
            end
            if (n >= RUN_LIMIT) return;
        end
        run_len(1'b1, n);
        checks++;
        if (n != END_CYC) begin
            errors++;
            $display("FAIL %s end_low: got %0d, expected %0d", tag, n, END_CYC);
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end flags: frame_done=%b busy=%b, expected 1/0", tag, frame_done, busy);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s frame_done width: got %b one cycle later, expected 0", tag, frame_done);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s frame: got %h, expected %h", tag, got, exp);
        end
        $display("frame %s: decoded %h expected %h", tag, got, exp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        host_low = 1'b0;
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (dq_oe !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: dq_oe=%b busy=%b frame_done=%b, expected 0/0/0",
                     dq_oe, busy, frame_done);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.state_reg !== IDLE || dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: state=%0d dq_oe=%b, expected IDLE/0", dut.state_reg, dq_oe);
        end
        $display("reset: dq_oe=%b busy=%b frame_done=%b", dq_oe, busy, frame_done);
    endtask

    task automatic test_basic_frame();
        set_data(8'h35, 8'h00, 8'h18, 8'h05);
        host_start(START_CYC);
        capture_frame(40'h35_00_18_05_52, "basic");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_short_start();
        int bad;
        bad = 0;
        host_low = 1'b1;
        for (int i = 0; i < START_CYC - CPU; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        host_low = 1'b0;
        for (int i = 0; i < WAIT_CYC + RESP_LOW_CYC + 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || dq_oe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || dut.state_reg !== IDLE) begin
            errors++;
            $display("FAIL short_start: %0d cycles with busy/dq_oe high, state=%0d, expected 0/IDLE",
                     bad, dut.state_reg);
        end
        $display("short start (%0d cycles low): bad cycles %0d", START_CYC - CPU, bad);
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        host_low = 1'b1;
        @(negedge clk);
        host_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || dq_oe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || dut.state_reg !== IDLE) begin
            errors++;
            $display("FAIL glitch: %0d cycles with busy/dq_oe high, state=%0d, expected 0/IDLE",
                     bad, dut.state_reg);
        end
        $display("glitch: bad cycles %0d", bad);
    endtask

    task automatic test_reset_mid_frame();
        int lat, n, bad, fd0;
        bad = 0;
        fd0 = fd_cnt;
        set_data(8'h35, 8'h00, 8'h18, 8'h05);
        host_start(START_CYC);
        wait_oe_high(lat);
        run_len(1'b1, n);
        run_len(1'b0, n);
        for (int i = 0; i < 12; i++) begin
            run_len(1'b1, n);
            run_len(1'b0, n);
        end
        checks++;
        if (dq_oe !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame reach bit12: dq_oe=%b, expected 1", dq_oe);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dq_oe !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame reset: dq_oe=%b busy=%b frame_done=%b, expected 0/0/0",
                     dq_oe, busy, frame_done);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dq_oe !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || fd_cnt != fd0) begin
            errors++;
            $display("FAIL mid_frame resume: %0d active cycles, %0d frame_done pulses, expected 0/0",
                     bad, fd_cnt - fd0);
        end
        $display("reset during bit 12: active cycles after reset %0d", bad);
    endtask

    task automatic test_back_to_back();
        int fd0;
        fd0 = fd_cnt;
        set_data(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        host_start(START_CYC);
        capture_frame(40'hFF_FF_FF_FF_FC, "all_ff");
        repeat (5) @(negedge clk);
        set_data(8'h01, 8'h02, 8'h03, 8'h04);
        host_start(START_CYC);
        capture_frame(40'h01_02_03_04_0A, "back_to_back");
        checks++;
        if (fd_cnt - fd0 != 2) begin
            errors++;
            $display("FAIL back_to_back pulses: got %0d frame_done pulses, expected 2", fd_cnt - fd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        host_low = 1'b0;
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_short_start();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
